mc_ctrl: RTL and testbench

- Multi-cycle control sequencer for the existing MIPS datapath (IFU/NPC/RF/ALU/EXT/DM) plus an external mult/div unit.
- Replaces the single-cycle combinational decoder with an FSM, so each instruction takes 3–5+ cycles.
- Decodes the latched instruction's opcode/funct and drives write enables, mux selects and op codes, one state per cycle.
- Supports stall on a configurable memory wait and on the mult/div busy flag.

---
 rtl/mc_pkg.sv | 87 ++++++++
 rtl/mc_decode.sv | 69 ++++++
 rtl/mc_ctrl.sv | 124 ++++++++++++
 tb/tb_mc_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared state, opcode/funct and datapath select encodings for the multi-cycle controller
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXE    = 4'd2,
        S_MEM_RD = 4'd3,
        S_MEM_WR = 4'd4,
        S_WB     = 4'd5,
        S_BR     = 4'd6,
        S_JMP    = 4'd7,
        S_MDWAIT = 4'd8
    } state_t;

    typedef enum logic [3:0] {
        C_UNK, C_ALU, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_JR, C_MD, C_MF
    } cls_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_JR    = 6'h08;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_SLT   = 6'h2A;

    localparam logic [2:0] NPC_PC4 = 3'd0;
    localparam logic [2:0] NPC_BR  = 3'd1;
    localparam logic [2:0] NPC_J   = 3'd2;
    localparam logic [2:0] NPC_JR  = 3'd3;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;

    localparam logic [2:0] EXT_ZERO = 3'd0;
    localparam logic [2:0] EXT_SIGN = 3'd1;
    localparam logic [2:0] EXT_LUI  = 3'd2;

    localparam logic [2:0] ALU_B_RD2 = 3'd0;
    localparam logic [2:0] ALU_B_EXT = 3'd1;

    localparam logic [2:0] RF_A3_RD = 3'd0;
    localparam logic [2:0] RF_A3_RT = 3'd1;
    localparam logic [2:0] RF_A3_31 = 3'd2;

    localparam logic [2:0] RF_WD_ALU = 3'd0;
    localparam logic [2:0] RF_WD_DM  = 3'd1;
    localparam logic [2:0] RF_WD_PC4 = 3'd2;
    localparam logic [2:0] RF_WD_EXT = 3'd3;
    localparam logic [2:0] RF_WD_HI  = 3'd4;
    localparam logic [2:0] RF_WD_LO  = 3'd5;

    localparam logic [1:0] MD_MULT  = 2'd0;
    localparam logic [1:0] MD_MULTU = 2'd1;
    localparam logic [1:0] MD_DIV   = 2'd2;
    localparam logic [1:0] MD_DIVU  = 2'd3;

    typedef struct packed {
        cls_t       cls;
        logic [2:0] jmp_op;
        logic [3:0] alu_op;
        logic [2:0] ext_op;
        logic [2:0] alu_b_sel;
        logic [2:0] rf_a3_sel;
        logic [2:0] rf_wd_sel;
        logic [1:0] md_op;
    } dec_t;

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational op/funct decode into instruction class and datapath selects
module mc_decode
    import mc_pkg::*;
#(
    parameter bit MD_EN = 1'b1
) (
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output dec_t       dec
);

    // class and selects; unsupported encodings stay C_UNK and retire as a nop
    always_comb begin
        dec = '{cls: C_UNK, jmp_op: NPC_J, alu_op: ALU_ADD, ext_op: EXT_SIGN, alu_b_sel: ALU_B_RD2,
                rf_a3_sel: RF_A3_RD, rf_wd_sel: RF_WD_ALU, md_op: funct[1:0]};
        case (op)
            OP_RTYPE: begin
                case (funct)
                    F_ADDU: dec.cls = C_ALU;
                    F_SUBU: begin dec.cls = C_ALU; dec.alu_op = ALU_SUB; end
                    F_AND:  begin dec.cls = C_ALU; dec.alu_op = ALU_AND; end
                    F_OR:   begin dec.cls = C_ALU; dec.alu_op = ALU_OR; end
                    F_SLT:  begin dec.cls = C_ALU; dec.alu_op = ALU_SLT; end
                    F_JR:   begin dec.cls = C_JR; dec.jmp_op = NPC_JR; end
                    F_MFHI: begin dec.cls = MD_EN ? C_MF : C_UNK; dec.rf_wd_sel = RF_WD_HI; end
                    F_MFLO: begin dec.cls = MD_EN ? C_MF : C_UNK; dec.rf_wd_sel = RF_WD_LO; end
                    F_MULT, F_MULTU, F_DIV, F_DIVU: dec.cls = MD_EN ? C_MD : C_UNK;
                    default: ;
                endcase
            end
            OP_ORI: begin
                dec.cls       = C_ALU;
                dec.alu_op    = ALU_OR;
                dec.ext_op    = EXT_ZERO;
                dec.alu_b_sel = ALU_B_EXT;
                dec.rf_a3_sel = RF_A3_RT;
            end
            OP_LUI: begin
                dec.cls       = C_ALU;
                dec.ext_op    = EXT_LUI;
                dec.alu_b_sel = ALU_B_EXT;
                dec.rf_a3_sel = RF_A3_RT;
                dec.rf_wd_sel = RF_WD_EXT;
            end
            OP_LW: begin
                dec.cls       = C_LW;
                dec.alu_b_sel = ALU_B_EXT;
                dec.rf_a3_sel = RF_A3_RT;
                dec.rf_wd_sel = RF_WD_DM;
            end
            OP_SW: begin
                dec.cls       = C_SW;
                dec.alu_b_sel = ALU_B_EXT;
            end
            OP_BEQ: begin
                dec.cls    = C_BEQ;
                dec.alu_op = ALU_SUB;
            end
            OP_J: dec.cls = C_J;
            OP_JAL: begin
                dec.cls       = C_JAL;
                dec.rf_a3_sel = RF_A3_31;
                dec.rf_wd_sel = RF_WD_PC4;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM with memory wait and mult/div stall handling
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 0,
    parameter bit          MD_EN    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       cmp,
    input  logic       md_busy,
    output logic [3:0] state,
    output logic       ir_wr,
    output logic       pc_wr,
    output logic       rf_wr,
    output logic       dm_wr,
    output logic       md_start,
    output logic [1:0] md_op,
    output logic [2:0] npc_op,
    output logic [3:0] alu_op,
    output logic [2:0] ext_op,
    output logic [2:0] alu_b_sel,
    output logic [2:0] rf_a3_sel,
    output logic [2:0] rf_wd_sel
);

    state_t     state_q, state_d;
    logic [3:0] wcnt_q, wcnt_d;
    dec_t       dec;
    logic       md_stall, mem_st, mem_last;

    mc_decode #(.MD_EN(MD_EN)) u_decode (.op(op), .funct(funct), .dec(dec));

    assign md_stall  = (dec.cls == C_MD || dec.cls == C_MF) && md_busy;
    assign mem_st    = state_q == S_MEM_RD || state_q == S_MEM_WR;
    assign mem_last  = wcnt_q == 4'(MEM_WAIT);
    assign wcnt_d    = (mem_st && !mem_last) ? wcnt_q + 4'd1 : 4'd0;
    assign state     = state_q;
    assign md_op     = dec.md_op;
    assign alu_op    = dec.alu_op;
    assign ext_op    = dec.ext_op;
    assign alu_b_sel = dec.alu_b_sel;
    assign rf_a3_sel = dec.rf_a3_sel;
    assign rf_wd_sel = dec.rf_wd_sel;

    // next state and Moore enables; reset suppresses every enable in its own cycle
    always_comb begin
        state_d  = state_q;
        ir_wr    = 1'b0;
        pc_wr    = 1'b0;
        rf_wr    = 1'b0;
        dm_wr    = 1'b0;
        md_start = 1'b0;
        npc_op   = NPC_PC4;
        case (state_q)
            S_FETCH: begin
                ir_wr   = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                pc_wr = dec.cls == C_UNK;
                if (!md_stall)
                    state_d = dec.cls == C_UNK ? S_FETCH :
                              dec.cls == C_BEQ ? S_BR :
                              (dec.cls == C_J || dec.cls == C_JAL || dec.cls == C_JR) ? S_JMP :
                              dec.cls == C_MF ? S_WB : S_EXE;
            end
            S_EXE: begin
                md_start = dec.cls == C_MD;
                state_d  = dec.cls == C_LW ? S_MEM_RD :
                           dec.cls == C_SW ? S_MEM_WR :
                           dec.cls == C_MD ? S_MDWAIT : S_WB;
            end
            S_MEM_RD: if (mem_last) state_d = S_WB;
            S_MEM_WR: begin
                dm_wr = mem_last;
                pc_wr = mem_last;
                if (mem_last) state_d = S_FETCH;
            end
            S_WB: begin
                rf_wr   = 1'b1;
                pc_wr   = 1'b1;
                state_d = S_FETCH;
            end
            S_BR: begin
                pc_wr   = 1'b1;
                npc_op  = cmp ? NPC_BR : NPC_PC4;
                state_d = S_FETCH;
            end
            S_JMP: begin
                pc_wr   = 1'b1;
                npc_op  = dec.jmp_op;
                rf_wr   = dec.cls == C_JAL;
                state_d = S_FETCH;
            end
            S_MDWAIT: begin
                pc_wr = !md_busy;
                if (!md_busy) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        if (reset) begin
            ir_wr    = 1'b0;
            pc_wr    = 1'b0;
            rf_wr    = 1'b0;
            dm_wr    = 1'b0;
            md_start = 1'b0;
        end
    end

    // state and memory wait counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            wcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed-vector bench for mc_ctrl with MEM_WAIT=0 and MEM_WAIT=2 instances
module tb_mc_ctrl;
    import mc_pkg::*;

    logic       clk = 1'b0, reset = 1'b1, cmp = 1'b0, md_busy = 1'b0;
    logic [5:0] op = 6'h3F, funct = 6'h00;
    int         nvec = 0, nerr = 0;

    logic [3:0] s0_state, s2_state, s0_alu_op, s2_alu_op;
    logic       s0_ir_wr, s0_pc_wr, s0_rf_wr, s0_dm_wr, s0_md_start;
    logic       s2_ir_wr, s2_pc_wr, s2_rf_wr, s2_dm_wr, s2_md_start;
    logic [1:0] s0_md_op, s2_md_op;
    logic [2:0] s0_npc_op, s0_ext_op, s0_alu_b_sel, s0_rf_a3_sel, s0_rf_wd_sel;
    logic [2:0] s2_npc_op, s2_ext_op, s2_alu_b_sel, s2_rf_a3_sel, s2_rf_wd_sel;
    logic [8:0] obs0, obs2;

    assign obs0 = {s0_state, s0_ir_wr, s0_pc_wr, s0_rf_wr, s0_dm_wr, s0_md_start};
    assign obs2 = {s2_state, s2_ir_wr, s2_pc_wr, s2_rf_wr, s2_dm_wr, s2_md_start};

    always #5 clk = ~clk;

    mc_ctrl #(.MEM_WAIT(0)) u0 (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .cmp(cmp), .md_busy(md_busy),
        .state(s0_state), .ir_wr(s0_ir_wr), .pc_wr(s0_pc_wr), .rf_wr(s0_rf_wr), .dm_wr(s0_dm_wr),
        .md_start(s0_md_start), .md_op(s0_md_op), .npc_op(s0_npc_op), .alu_op(s0_alu_op),
        .ext_op(s0_ext_op), .alu_b_sel(s0_alu_b_sel), .rf_a3_sel(s0_rf_a3_sel), .rf_wd_sel(s0_rf_wd_sel));

    mc_ctrl #(.MEM_WAIT(2)) u2 (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .cmp(cmp), .md_busy(md_busy),
        .state(s2_state), .ir_wr(s2_ir_wr), .pc_wr(s2_pc_wr), .rf_wr(s2_rf_wr), .dm_wr(s2_dm_wr),
        .md_start(s2_md_start), .md_op(s2_md_op), .npc_op(s2_npc_op), .alu_op(s2_alu_op),
        .ext_op(s2_ext_op), .alu_b_sel(s2_alu_b_sel), .rf_a3_sel(s2_rf_a3_sel), .rf_wd_sel(s2_rf_wd_sel));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        tick;
        #4;
        nvec += 2;
        if (obs0 !== 9'h000) begin nerr++; $display("FAIL reset_hold u0 got %h want %h", obs0, 9'h000); end
        if (obs2 !== 9'h000) begin nerr++; $display("FAIL reset_hold u2 got %h want %h", obs2, 9'h000); end
        tick;
        reset = 1'b0;
        #4;
        nvec += 2;
        if (obs0 !== {4'd0, 5'b10000}) begin nerr++; $display("FAIL reset_fetch u0 got %h want %h", obs0, {4'd0, 5'b10000}); end
        if (obs2 !== {4'd0, 5'b10000}) begin nerr++; $display("FAIL reset_fetch u2 got %h want %h", obs2, {4'd0, 5'b10000}); end
    endtask

    task automatic test_addu;
        logic [8:0] e [5];
        e = '{{4'd0, 5'b10000}, {4'd1, 5'b00000}, {4'd2, 5'b00000}, {4'd5, 5'b01100}, {4'd0, 5'b10000}};
        op = 6'h00; funct = 6'h21;
        do_reset;
        for (int c = 0; c < 5; c++) begin
            #4;
            nvec += 2;
            if (obs0 !== e[c]) begin nerr++; $display("FAIL addu c%0d u0 got %h want %h", c + 1, obs0, e[c]); end
            if (obs2 !== e[c]) begin nerr++; $display("FAIL addu c%0d u2 got %h want %h", c + 1, obs2, e[c]); end
            if (c == 2) begin
                nvec++;
                if ({s0_alu_op, s0_alu_b_sel} !== {ALU_ADD, ALU_B_RD2}) begin
                    nerr++; $display("FAIL addu_exe alu/b got %h/%h want %h/%h", s0_alu_op, s0_alu_b_sel, ALU_ADD, ALU_B_RD2);
                end
            end
            if (c == 3) begin
                nvec++;
                if ({s0_rf_a3_sel, s0_rf_wd_sel, s0_npc_op} !== {RF_A3_RD, RF_WD_ALU, NPC_PC4}) begin
                    nerr++; $display("FAIL addu_wb a3/wd/npc got %h/%h/%h", s0_rf_a3_sel, s0_rf_wd_sel, s0_npc_op);
                end
            end
            tick;
        end
    endtask

    task automatic test_lw;
        logic [8:0] e [8];
        e = '{{4'd0, 5'b10000}, {4'd1, 5'b00000}, {4'd2, 5'b00000}, {4'd3, 5'b00000},
              {4'd3, 5'b00000}, {4'd3, 5'b00000}, {4'd5, 5'b01100}, {4'd0, 5'b10000}};
        op = 6'h23; funct = 6'h00;
        do_reset;
        for (int c = 0; c < 8; c++) begin
            #4;
            nvec++;
            if (obs2 !== e[c]) begin nerr++; $display("FAIL lw_w2 c%0d got %h want %h", c + 1, obs2, e[c]); end
            if (c < 4) begin
                nvec++;
                if (obs0 !== e[c]) begin nerr++; $display("FAIL lw_w0 c%0d got %h want %h", c + 1, obs0, e[c]); end
            end
            if (c == 4) begin
                nvec++;
                if (obs0 !== {4'd5, 5'b01100}) begin nerr++; $display("FAIL lw_w0 c5 got %h want %h", obs0, {4'd5, 5'b01100}); end
            end
            if (c == 2) begin
                nvec++;
                if ({s2_alu_op, s2_alu_b_sel, s2_ext_op} !== {ALU_ADD, ALU_B_EXT, EXT_SIGN}) begin
                    nerr++; $display("FAIL lw_exe alu/b/ext got %h/%h/%h", s2_alu_op, s2_alu_b_sel, s2_ext_op);
                end
            end
            if (c == 6) begin
                nvec++;
                if ({s2_rf_a3_sel, s2_rf_wd_sel} !== {RF_A3_RT, RF_WD_DM}) begin
                    nerr++; $display("FAIL lw_wb a3/wd got %h/%h want %h/%h", s2_rf_a3_sel, s2_rf_wd_sel, RF_A3_RT, RF_WD_DM);
                end
            end
            tick;
        end
    endtask

    task automatic test_sw;
        logic [8:0] e0 [5];
        logic [8:0] e2 [7];
        int dm0, rf_any;
        e0 = '{{4'd0, 5'b10000}, {4'd1, 5'b00000}, {4'd2, 5'b00000}, {4'd4, 5'b01010}, {4'd0, 5'b10000}};
        e2 = '{{4'd0, 5'b10000}, {4'd1, 5'b00000}, {4'd2, 5'b00000}, {4'd4, 5'b00000},
               {4'd4, 5'b00000}, {4'd4, 5'b01010}, {4'd0, 5'b10000}};
        dm0 = 0; rf_any = 0;
        op = 6'h2B; funct = 6'h00;
        do_reset;
        for (int c = 0; c < 7; c++) begin
            #4;
            dm0 += int'(s0_dm_wr);
            rf_any += int'(s0_rf_wr) + int'(s2_rf_wr);
            nvec++;
            if (obs2 !== e2[c]) begin nerr++; $display("FAIL sw_w2 c%0d got %h want %h", c + 1, obs2, e2[c]); end
            if (c < 5) begin
                nvec++;
                if (obs0 !== e0[c]) begin nerr++; $display("FAIL sw_w0 c%0d got %h want %h", c + 1, obs0, e0[c]); end
            end
            tick;
        end
        nvec += 2;
        if (dm0 !== 1) begin nerr++; $display("FAIL sw_dm_count got %0d want 1", dm0); end
        if (rf_any !== 0) begin nerr++; $display("FAIL sw_rf_count got %0d want 0", rf_any); end
    endtask

    task automatic test_branch;
        logic [5:0] t_op [5];
        logic [5:0] t_fn [5];
        logic       t_cmp [5];
        logic [8:0] t_obs [5];
        logic [2:0] t_npc [5];
        logic [8:0] e;
        t_op  = '{6'h04, 6'h04, 6'h02, 6'h03, 6'h00};
        t_fn  = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h08};
        t_cmp = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        t_obs = '{{4'd6, 5'b01000}, {4'd6, 5'b01000}, {4'd7, 5'b01000}, {4'd7, 5'b01100}, {4'd7, 5'b01000}};
        t_npc = '{NPC_BR, NPC_PC4, NPC_J, NPC_J, NPC_JR};
        for (int i = 0; i < 5; i++) begin
            op = t_op[i]; funct = t_fn[i]; cmp = t_cmp[i];
            do_reset;
            for (int c = 0; c < 4; c++) begin
                e = c == 0 || c == 3 ? {4'd0, 5'b10000} : c == 1 ? {4'd1, 5'b00000} : t_obs[i];
                #4;
                nvec++;
                if (obs0 !== e) begin nerr++; $display("FAIL branch%0d c%0d got %h want %h", i, c + 1, obs0, e); end
                if (c == 2) begin
                    nvec++;
                    if (s0_npc_op !== t_npc[i]) begin nerr++; $display("FAIL branch%0d npc got %h want %h", i, s0_npc_op, t_npc[i]); end
                    if (i == 3) begin
                        nvec++;
                        if ({s0_rf_a3_sel, s0_rf_wd_sel} !== {RF_A3_31, RF_WD_PC4}) begin
                            nerr++; $display("FAIL jal a3/wd got %h/%h want %h/%h", s0_rf_a3_sel, s0_rf_wd_sel, RF_A3_31, RF_WD_PC4);
                        end
                    end
                end
                tick;
            end
        end
        cmp = 1'b0;
    endtask

    task automatic test_mult;
        logic       bz [15];
        logic [5:0] fn [15];
        logic [8:0] e [15];
        logic [8:0] ed [5];
        bz = '{0, 0, 0, 1, 1, 1, 1, 1, 0, 1, 1, 1, 0, 0, 0};
        fn = '{6'h18, 6'h18, 6'h18, 6'h18, 6'h18, 6'h18, 6'h18, 6'h18, 6'h18,
               6'h12, 6'h12, 6'h12, 6'h12, 6'h12, 6'h12};
        e  = '{{4'd0, 5'b10000}, {4'd1, 5'b00000}, {4'd2, 5'b00001}, {4'd8, 5'b00000},
               {4'd8, 5'b00000}, {4'd8, 5'b00000}, {4'd8, 5'b00000}, {4'd8, 5'b00000},
               {4'd8, 5'b01000}, {4'd0, 5'b10000}, {4'd1, 5'b00000}, {4'd1, 5'b00000},
               {4'd1, 5'b00000}, {4'd5, 5'b01100}, {4'd0, 5'b10000}};
        op = 6'h00; funct = 6'h18; md_busy = 1'b0;
        do_reset;
        for (int c = 0; c < 15; c++) begin
            md_busy = bz[c]; funct = fn[c];
            #4;
            nvec += 2;
            if (obs0 !== e[c]) begin nerr++; $display("FAIL mult c%0d u0 got %h want %h", c + 1, obs0, e[c]); end
            if (obs2 !== e[c]) begin nerr++; $display("FAIL mult c%0d u2 got %h want %h", c + 1, obs2, e[c]); end
            if (c == 2) begin
                nvec++;
                if (s0_md_op !== MD_MULT) begin nerr++; $display("FAIL mult md_op got %h want %h", s0_md_op, MD_MULT); end
            end
            if (c == 13) begin
                nvec++;
                if ({s0_rf_a3_sel, s0_rf_wd_sel} !== {RF_A3_RD, RF_WD_LO}) begin
                    nerr++; $display("FAIL mflo a3/wd got %h/%h want %h/%h", s0_rf_a3_sel, s0_rf_wd_sel, RF_A3_RD, RF_WD_LO);
                end
            end
            tick;
        end
        ed = '{{4'd0, 5'b10000}, {4'd1, 5'b00000}, {4'd2, 5'b00001}, {4'd8, 5'b01000}, {4'd0, 5'b10000}};
        md_busy = 1'b0; funct = 6'h1B;
        do_reset;
        for (int c = 0; c < 5; c++) begin
            #4;
            nvec++;
            if (obs0 !== ed[c]) begin nerr++; $display("FAIL divu c%0d got %h want %h", c + 1, obs0, ed[c]); end
            if (c == 2) begin
                nvec++;
                if (s0_md_op !== MD_DIVU) begin nerr++; $display("FAIL divu md_op got %h want %h", s0_md_op, MD_DIVU); end
            end
            tick;
        end
    endtask

    task automatic test_abort;
        logic [8:0] e;
        int         wr;
        for (int ac = 5; ac <= 6; ac++) begin
            op = 6'h2B; funct = 6'h00;
            do_reset;
            wr = 0;
            for (int c = 1; c <= 7; c++) begin
                reset = c == ac;
                e = c == 1 ? {4'd0, 5'b10000} : c == 2 ? {4'd1, 5'b00000} : c == 3 ? {4'd2, 5'b00000} :
                    c <= ac ? {4'd4, 5'b00000} : c == ac + 1 ? {4'd0, 5'b10000} : {4'd1, 5'b00000};
                #4;
                wr += int'(s2_dm_wr) + int'(s2_pc_wr);
                nvec++;
                if (obs2 !== e) begin nerr++; $display("FAIL abort%0d c%0d got %h want %h", ac, c, obs2, e); end
                tick;
            end
            reset = 1'b0;
            nvec++;
            if (wr !== 0) begin nerr++; $display("FAIL abort%0d dm/pc pulses got %0d want 0", ac, wr); end
        end
    endtask

    task automatic test_unknown;
        logic [8:0] e [3];
        e = '{{4'd0, 5'b10000}, {4'd1, 5'b01000}, {4'd0, 5'b10000}};
        op = 6'h3F; funct = 6'h00;
        do_reset;
        for (int c = 0; c < 3; c++) begin
            #4;
            nvec += 2;
            if (obs0 !== e[c]) begin nerr++; $display("FAIL unknown c%0d u0 got %h want %h", c + 1, obs0, e[c]); end
            if (obs2 !== e[c]) begin nerr++; $display("FAIL unknown c%0d u2 got %h want %h", c + 1, obs2, e[c]); end
            if (c == 1) begin
                nvec++;
                if (s0_npc_op !== NPC_PC4) begin nerr++; $display("FAIL unknown npc got %h want %h", s0_npc_op, NPC_PC4); end
            end
            tick;
        end
    endtask

    initial begin
        test_reset;
        test_addu;
        test_lw;
        test_sw;
        test_branch;
        test_mult;
        test_abort;
        test_unknown;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
